// File: rtl/step_sequencer.sv
// step_sequencer: turns throttle slow_clk edges into single-cycle steps of a wrapping position counter,
// with a run/hold/idle FSM and blanking of the edge a rate change can produce.
module step_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int POS_W     = 3
) (
  input  logic             CLK_50,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic [2:0]       freq_num,
  input  logic             run_en,
  input  logic             dir,
  input  logic             clear,
  output logic             step_pulse,
  output logic             wrap_pulse,
  output logic [POS_W-1:0] position,
  output logic [1:0]       state,
  output logic [2:0]       rate_q,
  output logic             freq_chg
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} state_t;
  localparam logic [POS_W-1:0] LAST = POS_W'(NUM_STEPS - 1);
  state_t state_q, state_d;
  logic s0_q, s1_q, s2_q;
  logic blank_q, blank_d, step_q, step_d, wrap_q, wrap_d, chg_q, chg_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [2:0] rate_d;
  logic tick, chg, acc, at_end;
  always_comb begin
    tick    = s1_q & ~s2_q;
    chg     = freq_num != rate_q;
    rate_d  = freq_num;
    chg_d   = chg;
    // a tick coinciding with a fresh rate change is dropped and leaves blank armed
    blank_d = clear ? 1'b0 : chg ? 1'b1 : tick ? 1'b0 : blank_q;
    acc     = tick & ~blank_q & ~chg & ~clear & run_en & (state_q == RUN);
    at_end  = dir ? (pos_q == LAST) : (pos_q == '0);
    pos_d   = clear ? '0 : !acc ? pos_q : at_end ? (dir ? '0 : LAST)
            : dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    state_d = clear ? IDLE : run_en ? RUN : (state_q == IDLE) ? IDLE : HOLD;
    step_d  = acc;
    wrap_d  = acc & at_end;
  end
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      blank_q <= 1'b0;
      rate_q  <= '0;
      chg_q   <= 1'b0;
      state_q <= IDLE;
      pos_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      s0_q    <= slow_clk;
      s1_q    <= s0_q;
      s2_q    <= s1_q;
      blank_q <= blank_d;
      rate_q  <= rate_d;
      chg_q   <= chg_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end
  assign step_pulse = step_q;
  assign wrap_pulse = wrap_q;
  assign position   = pos_q;
  assign state      = state_q;
  assign freq_chg   = chg_q;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: scoreboard bench; expected steps are queued when a slow_clk rise is driven
// and popped when step_pulse appears, checking position, wrap and latency.
module tb_step_sequencer;
  logic CLK_50 = 1'b0;
  logic reset, slow_clk, run_en, dir, clear;
  logic [2:0] freq_num;
  logic step_pulse, wrap_pulse, freq_chg;
  logic [2:0] position, rate_q;
  logic [1:0] state;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  typedef struct {logic [2:0] pos; logic wrap; int cyc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [2:0] exp_pos;

  step_sequencer dut (
    .CLK_50(CLK_50), .reset(reset), .slow_clk(slow_clk), .freq_num(freq_num),
    .run_en(run_en), .dir(dir), .clear(clear), .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse), .position(position), .state(state),
    .rate_q(rate_q), .freq_chg(freq_chg)
  );

  always #5 CLK_50 = ~CLK_50;
  always @(posedge CLK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge CLK_50) begin
    if (step_pulse) begin
      if (sb.size() == 0) chk("unexpected_step", step_pulse, 0);
      else begin
        mon_e = sb.pop_front();
        chk("step_pos", position, mon_e.pos);
        chk("step_wrap", wrap_pulse, mon_e.wrap);
        chk("step_latency", cyc, mon_e.cyc);
      end
    end else if (wrap_pulse) chk("wrap_without_step", wrap_pulse, step_pulse);
  end

  task automatic rise(input bit acc);
    exp_t e;
    logic w;
    if (acc) begin
      w = dir ? (exp_pos == 3'd7) : (exp_pos == 3'd0);
      exp_pos = dir ? (w ? 3'd0 : exp_pos + 3'd1) : (w ? 3'd7 : exp_pos - 3'd1);
      e.pos = exp_pos;
      e.wrap = w;
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    slow_clk = 1'b1;
    repeat (20) @(negedge CLK_50);
    slow_clk = 1'b0;
    repeat (20) @(negedge CLK_50);
  endtask

  initial begin
    reset = 1'b1; slow_clk = 1'b0; run_en = 1'b0; dir = 1'b1; clear = 1'b0;
    freq_num = 3'd5; exp_pos = 3'd0;
    repeat (5) @(negedge CLK_50);
    chk("rst_state", state, 0);
    chk("rst_pos", position, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_wrap", wrap_pulse, 0);
    chk("rst_rate", rate_q, 0);
    chk("rst_chg", freq_chg, 0);
    reset = 1'b0; run_en = 1'b1;
    @(negedge CLK_50);
    chk("run_entry", state, 1);
    chk("chg_hi_5", freq_chg, 1);
    chk("rate_5", rate_q, 5);
    @(negedge CLK_50);
    chk("chg_lo_5", freq_chg, 0);
    rise(0);
    for (int i = 0; i < 8; i++) rise(1);
    chk("pending_up", sb.size(), 0);
    chk("pos_after_wrap", position, 0);
    dir = 1'b0;
    for (int i = 0; i < 5; i++) rise(1);
    chk("pos_down", position, 3);
    run_en = 1'b0;
    @(negedge CLK_50);
    chk("hold_entry", state, 2);
    for (int i = 0; i < 5; i++) rise(0);
    chk("hold_pos", position, 3);
    chk("hold_state", state, 2);
    run_en = 1'b1; dir = 1'b1;
    @(negedge CLK_50);
    chk("resume", state, 1);
    rise(1);
    chk("pos_resume", position, 4);
    freq_num = 3'd2;
    @(negedge CLK_50);
    chk("chg_hi_2", freq_chg, 1);
    rise(0);
    rise(1);
    chk("pos_5", position, 5);
    freq_num = 3'd3;
    @(negedge CLK_50);
    chk("chg_hi_3", freq_chg, 1);
    chk("rate_3", rate_q, 3);
    @(negedge CLK_50);
    chk("chg_lo_3", freq_chg, 0);
    rise(0);
    chk("pos_blanked", position, 5);
    rise(1);
    chk("pos_6", position, 6);
    slow_clk = 1'b1;
    repeat (2) @(negedge CLK_50);
    clear = 1'b1;
    @(negedge CLK_50);
    chk("clr_pos", position, 0);
    chk("clr_state", state, 0);
    chk("clr_step", step_pulse, 0);
    clear = 1'b0;
    @(negedge CLK_50);
    chk("clr_rerun", state, 1);
    repeat (17) @(negedge CLK_50);
    slow_clk = 1'b0;
    repeat (20) @(negedge CLK_50);
    exp_pos = 3'd0;
    for (int i = 0; i < 4; i++) rise(1);
    chk("pos_4", position, 4);
    repeat (3) @(negedge CLK_50);
    #1 reset = 1'b1;
    #1;
    chk("arst_pos", position, 0);
    chk("arst_state", state, 0);
    chk("arst_rate", rate_q, 0);
    @(negedge CLK_50);
    reset = 1'b0;
    @(negedge CLK_50);
    chk("arst_rerun", state, 1);
    chk("pending_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
